// File: rtl/div_result_bcd_if.sv
// div_result_bcd_if: bundles the two handshakes of the divider result stage.
//   Upstream side : in_valid/in_ready, quotient, remainder, div_err
//   Downstream side: out_valid/out_ready, q_bcd, rem_out (or rem_bcd), err_out
// Modports: slave = the conversion block, master = the producer/consumer around it.
// Optional feature macro: REM_BCD_EN (rem_bcd replaces rem_out).
interface div_result_bcd_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      quotient;
  logic [WIDTH-1:0]      remainder;
  logic                  div_err;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   q_bcd;
`ifdef REM_BCD_EN
  logic [4*DIGITS-1:0]   rem_bcd;
`else
  logic [WIDTH-1:0]      rem_out;
`endif
  logic                  err_out;

  modport slave (
    input  in_valid, quotient, remainder, div_err, out_ready,
    output in_ready, out_valid, q_bcd,
`ifdef REM_BCD_EN
    output rem_bcd,
`else
    output rem_out,
`endif
    output err_out
  );

  modport master (
    output in_valid, quotient, remainder, div_err, out_ready,
    input  in_ready, out_valid, q_bcd,
`ifdef REM_BCD_EN
    input  rem_bcd,
`else
    input  rem_out,
`endif
    input  err_out
  );
endinterface

// File: rtl/div_result_bcd.sv
// div_result_bcd: result stage of the 16-by-8 divider. Accepts a quotient /
// remainder / divide-by-zero triple, converts the quotient to packed BCD with a
// bit-serial double-dabble engine (one bit per clock), then holds the result
// for the display logic until it is taken.
// Ports:
//   clk    - clock, rising edge
//   clr_n  - synchronous active-low reset
//   bus    - div_result_bcd_if.slave (both valid/ready handshakes and data)
// Optional feature macro: REM_BCD_EN - remainder also converted to BCD in the
// same SHIFT cycles and driven on rem_bcd instead of binary rem_out.

// One nibble of the add-3 correction.
module div_result_bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

// One double-dabble step: correct every digit, then shift {bcd,bin} left by one.
module div_result_bcd_dd_step #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic [4*DIGITS-1:0] bcd_i,
  input  logic [WIDTH-1:0]    bin_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic [WIDTH-1:0]    bin_o
);
  logic [4*DIGITS-1:0] adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    div_result_bcd_add3 u_add3 (.nib_i(bcd_i[4*g +: 4]), .nib_o(adj[4*g +: 4]));
  end

  assign bcd_o = {adj[4*DIGITS-2:0], bin_i[WIDTH-1]};
  assign bin_o = {bin_i[WIDTH-2:0], 1'b0};
endmodule

module div_result_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  clr_n,
  div_result_bcd_if.slave       bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [4*DIGITS-1:0] q_bcd_q, q_bcd_d;
  logic                err_q, err_d;
  logic [4*DIGITS-1:0] bcd_n;
  logic [WIDTH-1:0]    bin_n;

  div_result_bcd_dd_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_q_step (
    .bcd_i(bcd_q), .bin_i(bin_q), .bcd_o(bcd_n), .bin_o(bin_n)
  );

`ifdef REM_BCD_EN
  // Second engine runs in lock-step with the quotient engine.
  logic [WIDTH-1:0]    rbin_q, rbin_d;
  logic [4*DIGITS-1:0] rbcd_q, rbcd_d;
  logic [4*DIGITS-1:0] rem_bcd_q, rem_bcd_d;
  logic [4*DIGITS-1:0] rbcd_n;
  logic [WIDTH-1:0]    rbin_n;

  div_result_bcd_dd_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_r_step (
    .bcd_i(rbcd_q), .bin_i(rbin_q), .bcd_o(rbcd_n), .bin_o(rbin_n)
  );
`else
  // Remainder captured at accept, copied to the output only on DONE entry so
  // the presented result never changes mid-hold.
  logic [WIDTH-1:0]    rem_hold_q, rem_hold_d;
  logic [WIDTH-1:0]    rem_out_q, rem_out_d;
`endif

  wire last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    q_bcd_d = q_bcd_q;
    err_d   = err_q;
`ifdef REM_BCD_EN
    rbin_d    = rbin_q;
    rbcd_d    = rbcd_q;
    rem_bcd_d = rem_bcd_q;
`else
    rem_hold_d = rem_hold_q;
    rem_out_d  = rem_out_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.div_err) begin
            // Blank code on every nibble; engine skipped.
            q_bcd_d = '1;
            err_d   = 1'b1;
`ifdef REM_BCD_EN
            rem_bcd_d = '1;
`else
            rem_out_d = '1;
`endif
            state_d = DONE;
          end else begin
            bin_d   = bus.quotient;
            bcd_d   = '0;
            cnt_d   = '0;
`ifdef REM_BCD_EN
            rbin_d  = bus.remainder;
            rbcd_d  = '0;
`else
            rem_hold_d = bus.remainder;
`endif
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        bin_d = bin_n;
        bcd_d = bcd_n;
        cnt_d = cnt_q + 1'b1;
`ifdef REM_BCD_EN
        rbin_d = rbin_n;
        rbcd_d = rbcd_n;
`endif
        if (last_bit) begin
          q_bcd_d = bcd_n;
          err_d   = 1'b0;
          cnt_d   = '0;
`ifdef REM_BCD_EN
          rem_bcd_d = rbcd_n;
`else
          rem_out_d = rem_hold_q;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      q_bcd_q <= '0;
      err_q   <= 1'b0;
`ifdef REM_BCD_EN
      rbin_q    <= '0;
      rbcd_q    <= '0;
      rem_bcd_q <= '0;
`else
      rem_hold_q <= '0;
      rem_out_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      q_bcd_q <= q_bcd_d;
      err_q   <= err_d;
`ifdef REM_BCD_EN
      rbin_q    <= rbin_d;
      rbcd_q    <= rbcd_d;
      rem_bcd_q <= rem_bcd_d;
`else
      rem_hold_q <= rem_hold_d;
      rem_out_q  <= rem_out_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.q_bcd     = q_bcd_q;
  assign bus.err_out   = err_q;
`ifdef REM_BCD_EN
  assign bus.rem_bcd   = rem_bcd_q;
`else
  assign bus.rem_out   = rem_out_q;
`endif
endmodule

// File: tb/tb_div_result_bcd.sv
// tb_div_result_bcd: directed-vector bench for div_result_bcd. Expected BCD
// values are hand-computed decimal renderings of the operands.
module tb_div_result_bcd;
  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  logic clk = 1'b0;
  logic clr_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  div_result_bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  div_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .clr_n(clr_n), .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // Advance one edge, settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rem(input string tag, input logic [15:0] rbin, input logic [19:0] rbcd);
`ifdef REM_BCD_EN
    chk(tag, 32'(bus.rem_bcd), 32'(rbcd));
`else
    chk(tag, 32'(bus.rem_out), 32'(rbin));
`endif
  endtask

  // Edges counted from the accept edge (=1) until out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [15:0] q, input logic [15:0] r,
                     input logic err, input int exp_lat, input logic [19:0] exp_q,
                     input logic [15:0] exp_rbin, input logic [19:0] exp_rbcd);
    int lat;
    chk({tag, "_in_ready_pre"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.quotient  = q;
    bus.remainder = r;
    bus.div_err   = err;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    bus.quotient  = 16'hDEAD;   // must be ignored after accept
    bus.remainder = 16'hBEEF;
    wait_valid(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_q"},   32'(bus.q_bcd), 32'(exp_q));
    chk_rem({tag, "_rem"}, exp_rbin, exp_rbcd);
    chk({tag, "_err"}, 32'(bus.err_out), 32'(err));
    chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    step();   // handshake edge
    chk({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready_post"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_q_held"}, 32'(bus.q_bcd), 32'(exp_q));
  endtask

  initial begin
    int lat;
    int seen_valid;
    clr_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.quotient  = '0;
    bus.remainder = '0;
    bus.div_err   = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_q_bcd",     32'(bus.q_bcd),     32'd0);
    chk("rst_err",       32'(bus.err_out),   32'd0);
    chk_rem("rst_rem", 16'h0, 20'h0);
    clr_n = 1'b1;
    step();

    run("v12345", 16'h3039, 16'h0007, 1'b0, 17, 20'h12345, 16'h0007, 20'h00007);
    run("vffff",  16'hFFFF, 16'h0010, 1'b0, 17, 20'h65535, 16'h0010, 20'h00016);
    run("vzero",  16'h0000, 16'h0000, 1'b0, 17, 20'h00000, 16'h0000, 20'h00000);
    run("verr",   16'h1234, 16'h0055, 1'b1, 1,  20'hFFFFF, 16'hFFFF, 20'hFFFFF);
    run("v257",   16'h0101, 16'h0003, 1'b0, 17, 20'h00257, 16'h0003, 20'h00003);
    run("v256",   16'h0100, 16'h00FF, 1'b0, 17, 20'h00256, 16'h00FF, 20'h00255);

    // Back-pressure: hold DONE 5 cycles while the next operand waits.
    bus.in_valid  = 1'b1;
    bus.quotient  = 16'd100;
    bus.remainder = 16'd1;
    bus.div_err   = 1'b0;
    bus.out_ready = 1'b0;
    step();
    bus.quotient  = 16'd200;
    bus.remainder = 16'd2;
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'd17);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_ov", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_ir", 32'(bus.in_ready),  32'd0);
      chk("bp_hold_q",  32'(bus.q_bcd),     32'h00100);
    end
    chk_rem("bp_hold_rem", 16'd1, 20'h00001);
    bus.out_ready = 1'b1;
    step();
    chk("bp_release_ir", 32'(bus.in_ready), 32'd1);
    chk("bp_release_ov", 32'(bus.out_valid), 32'd0);
    step();   // second operand accepted here
    chk("bp_second_acc", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    bus.quotient = 16'hDEAD;
    wait_valid(lat);
    chk("bp2_lat", 32'(lat), 32'd17);
    chk("bp2_q",   32'(bus.q_bcd), 32'h00200);
    chk_rem("bp2_rem", 16'd2, 20'h00002);
    step();

    // Reset mid-conversion aborts the result.
    bus.in_valid = 1'b1;
    bus.quotient = 16'h1234;
    bus.remainder = 16'h0009;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    clr_n = 1'b0;
    step();
    clr_n = 1'b1;
    chk("abort_ov",  32'(bus.out_valid), 32'd0);
    chk("abort_ir",  32'(bus.in_ready),  32'd1);
    chk("abort_q",   32'(bus.q_bcd),     32'd0);
    chk("abort_err", 32'(bus.err_out),   32'd0);
    chk_rem("abort_rem", 16'h0, 20'h0);
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.out_valid) seen_valid++;
    end
    chk("abort_no_valid", 32'(seen_valid), 32'd0);

    run("vpost", 16'h0101, 16'h0003, 1'b0, 17, 20'h00257, 16'h0003, 20'h00003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
